// File: rtl/mux21_pkg.sv
// Shared constants and helpers for the multiplexer_21 datapath leaf.
package mux21_pkg;

  // Default width of the select-toggle counter (legal range 4..32).
  localparam int CNT_W_DEFAULT = 16;

  // Data input indices chosen by select=0 and select=1.
  localparam int SEL_D0 = 0;
  localparam int SEL_D1 = 1;

  // Increment value by one, holding at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max);
    logic [31:0] res;
    if (value >= max) begin
      res = max;
    end else begin
      res = value + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux21_cell.sv
// Pure combinational 2:1 single-bit select. The conditional operator
// resolves an unknown select to the common value when both inputs agree,
// and to X otherwise.
module mux21_cell
  import mux21_pkg::*;
(
  input  logic [1:0] d,
  input  logic       select,
  output logic       q
);

  assign q = select ? d[SEL_D1] : d[SEL_D0];

endmodule

// File: rtl/multiplexer_21.sv
// 2:1 single-bit multiplexer: combinational q plus a registered copy q_r.
// Optional feature macro MUX21_STATS_EN adds a saturating counter of
// select transitions on the sel_toggles port.
module multiplexer_21
  import mux21_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       d,
  input  logic             select,
  output logic             q,
  output logic             q_r
`ifdef MUX21_STATS_EN
  ,
  output logic [CNT_W-1:0] sel_toggles
`endif
);

  mux21_cell u_cell (
    .d      (d),
    .select (select),
    .q      (q)
  );

  // Register the combinational result for timing-critical consumers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 1'b0;
    end else begin
      q_r <= q;
    end
  end

`ifdef MUX21_STATS_EN
  // All-ones value of a CNT_W-bit counter; the shift wraps to 0 at
  // CNT_W=32, so the subtraction still yields all ones.
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic             sel_prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next count: bump (saturating) whenever select differs from last edge.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (select != sel_prev_r) begin
      cnt_nxt_s = CNT_W'(sat_inc(32'(cnt_r), CNT_MAX));
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Track the previous select and the toggle count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_prev_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      sel_prev_r <= select;
      cnt_r      <= cnt_nxt_s;
    end
  end

  assign sel_toggles = cnt_r;
`endif

endmodule

// File: tb/tb_multiplexer_21.sv
// Directed self-checking bench for multiplexer_21. Counter checks are
// compiled in only when MUX21_STATS_EN is defined (counter width 4).
module tb_multiplexer_21;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] d;
  logic       select;
  logic       q;
  logic       q_r;
`ifdef MUX21_STATS_EN
  logic [3:0] sel_toggles;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  multiplexer_21 #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .select      (select),
    .q           (q),
    .q_r         (q_r)
`ifdef MUX21_STATS_EN
    ,
    .sel_toggles (sel_toggles)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Directed vectors: d, select, expected q.
  logic [1:0] vec_d   [7] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
  logic       vec_sel [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
  logic       vec_q   [7] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};

  initial begin
    logic prev_q;
    int   exp_cnt;

    rst_n  = 1'b0;
    d      = 2'b00;
    select = 1'b0;
    #3;
    check_val("reset_q_r", {31'd0, q_r}, 32'd0);
    check_val("reset_q", {31'd0, q}, 32'd0);
`ifdef MUX21_STATS_EN
    check_val("reset_cnt", {28'd0, sel_toggles}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Basic truth table, q immediately and q_r after one edge.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      d      = vec_d[i];
      select = vec_sel[i];
      #1;
      check_val($sformatf("q_vec%0d", i), {31'd0, q}, {31'd0, vec_q[i]});
      @(posedge clk);
      #1;
      check_val($sformatf("q_r_vec%0d", i), {31'd0, q_r}, {31'd0, vec_q[i]});
    end

    // Fresh reset, then five select toggles with d=11 so q_r ends at 1.
    @(negedge clk);
    rst_n = 1'b0;
    d      = 2'b11;
    select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      select = ~select;
      @(posedge clk);
      #1;
    end
    check_val("pre_rst_q_r", {31'd0, q_r}, 32'd1);
`ifdef MUX21_STATS_EN
    check_val("pre_rst_cnt", {28'd0, sel_toggles}, 32'd5);
`endif

    // Asynchronous reset in mid-cycle: registers clear, q keeps tracking.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_q_r", {31'd0, q_r}, 32'd0);
`ifdef MUX21_STATS_EN
    check_val("async_rst_cnt", {28'd0, sel_toggles}, 32'd0);
`endif
    check_val("rst_q_tracks_1", {31'd0, q}, 32'd1);
    d = 2'b01;
    #1;
    check_val("rst_q_tracks_0", {31'd0, q}, 32'd0);
    @(posedge clk);
    #1;
    check_val("rst_hold_q_r", {31'd0, q_r}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    select = 1'b0;
    d      = 2'b10;
    @(posedge clk);
    #1;
    check_val("post_rst_q_r", {31'd0, q_r}, 32'd0);
`ifdef MUX21_STATS_EN
    check_val("post_rst_cnt", {28'd0, sel_toggles}, 32'd0);
`endif

    // Toggle select every cycle for 20 cycles with d=10 (q follows select).
    prev_q  = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      select = ~select;
      #1;
      check_val($sformatf("tog_q%0d", i), {31'd0, q}, {31'd0, select});
      check_val($sformatf("tog_q_r_delay%0d", i), {31'd0, q_r}, {31'd0, prev_q});
      prev_q = select;
      @(posedge clk);
      #1;
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
`ifdef MUX21_STATS_EN
      check_val($sformatf("tog_cnt%0d", i), {28'd0, sel_toggles}, 32'(exp_cnt));
`endif
    end

    // Hold select (=0 after an even number of toggles) for 10 cycles,
    // varying d; count stays put and q_r lags q by one cycle.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d = 2'(i);
      #1;
      check_val($sformatf("hold_q%0d", i), {31'd0, q}, {31'd0, d[0]});
      check_val($sformatf("hold_q_r_delay%0d", i), {31'd0, q_r}, {31'd0, prev_q});
      prev_q = d[0];
      @(posedge clk);
      #1;
`ifdef MUX21_STATS_EN
      check_val($sformatf("hold_cnt%0d", i), {28'd0, sel_toggles}, 32'd15);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/multiplexer_21.md
# multiplexer_21

2:1 single-bit multiplexer with a zero-latency combinational output, plus a registered copy of that output for timing-critical consumers. It is a leaf block in the datapath, wherever one of two candidate bits is chosen by a control bit. An optional select-activity counter supports debug and coverage.

## Interface
Parameters:
- CNT_W, default 16: width of the select-toggle counter; legal range 4..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- d  input  [1:0]  data inputs; d[0] is chosen when select=0, d[1] when select=1.
- select  input  1  choice control.
- q  output  1  combinational result, q = d[select].
- q_r  output  1  q registered on clk.
- sel_toggles  output  [CNT_W-1:0]  count of select transitions. Present only when MUX21_STATS_EN is defined.

## Operation
- q is purely combinational: no clock dependence and no reset dependence.
- q = select ? d[1] : d[0].
- Combinational q X-handling:
  - If select is X/Z and d[1]==d[0], q equals that common value.
  - Otherwise q is X.
- q_r captures q on each rising clk edge.
- sel_prev is an internal register holding the previous select value; it is present only with MUX21_STATS_EN.
- sel_toggles:
  - Increments by 1 on each rising edge where select != sel_prev.
  - Saturates at 2^CNT_W-1 and never wraps.
- Reset (rst_n low, asynchronous):
  - q_r = 0, sel_prev = 0, sel_toggles = 0.
  - q continues to follow the inputs during reset.
- Reset deassertion is synchronized by the integrator. On the first rising edge after release, normal capture resumes.

## Timing
- q: 0 cycles, combinational propagation only.
- q_r: 1-cycle latency; value on cycle n+1 equals q sampled at edge n.
- sel_toggles: updated 1 cycle after the select change is sampled.
- Same-edge events:
  - select changes and the count is at saturation: count holds.
  - rst_n asserts on a clock edge: reset wins.
- Reset mid-operation clears all registers immediately; q is unaffected.

## Configuration
- MUX21_STATS_EN defined:
  - sel_prev and the saturating counter are built.
  - The sel_toggles port exists.
- MUX21_STATS_EN undefined:
  - No counter logic and no sel_toggles port.
  - q and q_r behaviour is identical to the defined case.

## Structure
- Package mux21_pkg holds:
  - Default CNT_W constant.
  - Index constants SEL_D0=0 and SEL_D1=1.
  - A saturating-increment function.
- Sub-module mux21_cell: pure combinational 2:1 select (d, select -> q), instantiated once. The top adds the registers and the stats logic.

## Test plan
- d=2'b00, select=0 -> q=0; after one clk, q_r=0.
- d=2'b11: select=0 -> q=1; select=1 -> q=1. Output is independent of select when both inputs are equal.
- d=2'b10: select=0 -> q=0; select=1 -> q=1. Also d=2'b01: select=0 -> q=1; select=1 -> q=0.
- rst_n=0 asynchronously mid-cycle with q_r=1 and sel_toggles=5 -> q_r=0 and sel_toggles=0 immediately, while q still tracks d[select].
- With MUX21_STATS_EN and CNT_W=4: toggle select every cycle for 20 cycles -> sel_toggles reaches 15 and stays at 15.
- Hold select constant for 10 cycles -> sel_toggles unchanged; q_r equals q one cycle delayed throughout.
